// File: rtl/ewat_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : ewat_pkg                                                      |
// | Description: Shared state encodings and width helpers for the EWAT feeder. |
// |              The optional pre-stage strobe is enabled with FEEDER_PIPE_EN. |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
package ewat_pkg;

    // Feeder FSM state encodings (3-bit register).
    localparam logic [2:0] c_FILL     = 3'd0;
    localparam logic [2:0] c_ISSUE_M1 = 3'd1;
    localparam logic [2:0] c_ISSUE    = 3'd2;
    localparam logic [2:0] c_WAIT     = 3'd3;
    localparam logic [2:0] c_HOLD     = 3'd4;

    // Tree result width: operand width plus one bit per tree level.
    function automatic int out_w(input int n_in, input int prec);
        return prec + $clog2(n_in);
    endfunction

    // Beat counter width; indexes lanes 0..N_IN-1.
    function automatic int cnt_w(input int n_in);
        return $clog2(n_in);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ewat_lane_buf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : ewat_lane_buf                                                 |
// | Description: N_IN x PREC lane registers with indexed write and a clear of  |
// |              lanes 1..N_IN-1, presented as one packed bus.                 |
// |              (Unaffected by FEEDER_PIPE_EN.)                               |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module ewat_lane_buf
    import ewat_pkg::*;
#(
    parameter int N_IN = 8,
    parameter int PREC = 7
) (
    input  logic                      CLK,
    input  logic                      RESET_N,
    input  logic                      wr_en,
    input  logic [cnt_w(N_IN)-1:0]    wr_idx,
    input  logic [PREC-1:0]           wr_data,
    input  logic                      clr_upper,
    output logic [N_IN*PREC-1:0]      lanes
);

    localparam int CNT_W = cnt_w(N_IN);

    genvar k;
    generate
        for (k = 0; k < N_IN; k++) begin : g_lane
            localparam logic [CNT_W-1:0] c_IDX = CNT_W'(k);
            logic [PREC-1:0] r_lane;

            // Take the operand addressed to this lane; a first beat zeroes every upper lane.
            always_ff @(posedge CLK or negedge RESET_N) begin
                if (!RESET_N) begin
                    r_lane <= '0;
                end else if (wr_en && (wr_idx == c_IDX)) begin
                    r_lane <= wr_data;
                end else if (wr_en && clr_upper && (k != 0)) begin
                    r_lane <= '0;
                end
            end

            assign lanes[PREC*k +: PREC] = r_lane;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/ewat_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : ewat_feeder                                                   |
// | Description: Collects up to N_IN signed operands, packs them for the EWAT  |
// |              adder tree, strobes the tree capture and returns the result   |
// |              on a valid/ready stream.                                      |
// |              Define FEEDER_PIPE_EN to add the addr_en_m1 pre-stage strobe. |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module ewat_feeder
    import ewat_pkg::*;
#(
    parameter int N_IN = 8,
    parameter int PREC = 7
) (
    input  logic                          CLK,
    input  logic                          RESET_N,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [PREC-1:0]               in_data,
    input  logic                          in_last,
    output logic [N_IN*PREC-1:0]          tree_in,
    output logic                          addr_en_m1,
    output logic                          addr_en,
    input  logic [out_w(N_IN, PREC)-1:0]  tree_out,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [out_w(N_IN, PREC)-1:0]  out_sum
);

    localparam int                CNT_W     = cnt_w(N_IN);
    localparam int                OUT_W     = out_w(N_IN, PREC);
    localparam logic [CNT_W-1:0]  c_CNT_MAX = CNT_W'(N_IN - 1);

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_in_ready;
    logic             r_addr_en;
    logic             r_out_valid;
    logic [OUT_W-1:0] r_out_sum;
    logic             w_accept;
    logic             w_fill_done;
    logic             w_first;

    // in_ready is only high in FILL, so an accepted beat always belongs to FILL.
    assign w_accept    = in_valid && r_in_ready;
    assign w_fill_done = w_accept && (in_last || (r_cnt == c_CNT_MAX));
    assign w_first     = (r_cnt == '0);

    ewat_lane_buf #(
        .N_IN (N_IN),
        .PREC (PREC)
    ) u_lane_buf (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .wr_en     (w_accept),
        .wr_idx    (r_cnt),
        .wr_data   (in_data),
        .clr_upper (w_first),
        .lanes     (tree_in)
    );

`ifdef FEEDER_PIPE_EN
    logic r_addr_en_m1;
    assign addr_en_m1 = r_addr_en_m1;
`else
    assign addr_en_m1 = 1'b0;
`endif

    // Feeder FSM: every output is registered and set on the transition into its state.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state      <= c_FILL;
            r_cnt        <= '0;
            r_in_ready   <= 1'b1;
            r_addr_en    <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_sum    <= '0;
`ifdef FEEDER_PIPE_EN
            r_addr_en_m1 <= 1'b0;
`endif
        end else begin
            case (r_state)
                c_FILL: begin
                    if (w_fill_done) begin
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
`ifdef FEEDER_PIPE_EN
                        r_state      <= c_ISSUE_M1;
                        r_addr_en_m1 <= 1'b1;
`else
                        r_state   <= c_ISSUE;
                        r_addr_en <= 1'b1;
`endif
                    end else if (w_accept) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`ifdef FEEDER_PIPE_EN
                c_ISSUE_M1: begin
                    r_addr_en_m1 <= 1'b0;
                    r_addr_en    <= 1'b1;
                    r_state      <= c_ISSUE;
                end
`endif
                c_ISSUE: begin
                    r_addr_en <= 1'b0;
                    r_state   <= c_WAIT;
                end
                c_WAIT: begin
                    // Tree output width already spans the full sum range; copy as-is.
                    r_out_sum   <= tree_out;
                    r_out_valid <= 1'b1;
                    r_state     <= c_HOLD;
                end
                c_HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= c_FILL;
                    end
                end
                default: begin
                    r_state     <= c_FILL;
                    r_cnt       <= '0;
                    r_in_ready  <= 1'b1;
                    r_addr_en   <= 1'b0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign addr_en   = r_addr_en;
    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;

endmodule
`default_nettype wire
